cra_diag_ctl: RTL and testbench
===============================

Name: cra_diag_ctl

Overview:
Diagnostic-side initiator for the CRA diagnostic port. It loads the 11-bit CRAM diagnostic address using DIAG functions 052 (high 5 bits) and 051 (low 6 bits). It reads back CRA state by stepping the diag[4:6] select through 0..7 while asserting the 14X read function, and assembles the captured EBUS fields into adr, loc, sbrRet, stackAdr and dispatch flags. It sits between the front-end/EBUS controller and the CRA.

Parameters:
STROBE_CYC, 1, cycles each write strobe (051/052) is held high; legal range 1..15.
SETTLE_CYC, 2, cycles diag select is held before capturing EBUS on a read; legal range 1..15.

Ports:
clk  in  1  system clock.
resetN  in  1  asynchronous active-low reset.
reqValid  in  1  command request.
reqReady  out  1  high only in IDLE; a command is accepted when reqValid & reqReady.
reqCmd  in  2  command: 00 NOP, 01 LOAD_ADR, 10 READ_ALL, 11 LOAD_THEN_READ.
reqAdr  in  11  CRAM address, bit 10 is LSB (KL numbering [0:10]).
done  out  1  one-cycle pulse when a command completes.
diaFunc051  out  1  write strobe for low address bits.
diaFunc052  out  1  write strobe for high address bits.
diagReadFunc14X  out  1  read-function enable.
diag  out  3  read select, equal to diag[4:6].
ebusOut  out  36  data driven onto EBUS during writes; zero otherwise.
ebusIn  in  36  EBUS read data; CRA fields are right-aligned in bits [29:35].
rdAdr  out  11  captured current CRAM address.
rdLoc  out  11  captured previous-cycle CRAM address.
rdSbrRet  out  11  captured subroutine return address.
rdStackAdr  out  5  captured stack pointer.
rdDisp  out  8  {dispEn00_07, dispEn00_03, dispEn30_37, CALL, DISP[0:4]} packed MSB-first; 9 source bits are listed, so 8 bits holds only the low 8 (CALL, DISP[0:4] and two enables). Final packing: {dispEn00_03, dispEn30_37, CALL, DISP[0:4]}.
parityErr  out  1  see Optional Feature.

Behaviour:
- Reset values (asynchronous): all outputs 0, except reqReady=1 once reset is released. Capture registers are 0. The state machine is in IDLE.
- States: IDLE, WR_HI, WR_LO, RD_SET, RD_WAIT, RD_CAP, FIN.
- IDLE:
  - Accepting a command latches reqCmd and reqAdr.
  - LOAD_ADR and LOAD_THEN_READ go to WR_HI.
  - READ_ALL goes to RD_SET.
  - NOP goes to FIN.
  - reqValid while reqReady=0 is ignored; the requester holds it.
- WR_HI:
  - ebusOut[1:5]=adr[0:4], all other bits 0.
  - diaFunc052=1 for STROBE_CYC cycles, then go to WR_LO.
- WR_LO:
  - ebusOut[0:5]=adr[5:10], all other bits 0.
  - diaFunc051=1 for STROBE_CYC cycles.
  - Then go to RD_SET with sel=0 if the command is LOAD_THEN_READ, otherwise go to FIN.
  - 051 and 052 are never high in the same cycle.
  - ebusOut is valid for the full duration of each strobe.
- RD_SET: diag=sel and diagReadFunc14X=1. This holds through RD_WAIT and RD_CAP.
- RD_WAIT: counts SETTLE_CYC-1 further cycles.
- RD_CAP: samples ebusIn[29:35] into field registers:
  - sel0: rdStackAdr=[31:35], dispEn00_03=[30].
  - sel1: CALL,DISP=[30:35].
  - sel2: rdSbrRet[5:10]=[30:35].
  - sel3: dispEn30_37=[30], rdSbrRet[0:4]=[31:35].
  - sel4: rdAdr[5:10]=[30:35].
  - sel5: paritySample=[30], rdAdr[0:4]=[31:35].
  - sel6: rdLoc[5:10]=[30:35].
  - sel7: rdLoc[0:4]=[31:35].
  - After capture: if sel=7 go to FIN; otherwise increment sel and go to RD_SET. sel is not wrapped.
- diagReadFunc14X drops in FIN.
- FIN: done=1 for one cycle, then return to IDLE.
- Latency, counted from the acceptance edge to the done pulse:
  - LOAD_ADR: 2*STROBE_CYC+1 cycles.
  - READ_ALL: 8*(SETTLE_CYC+1)+1 cycles.
  - LOAD_THEN_READ: the sum of the two minus 1.
- Field registers update only at their own RD_CAP. A LOAD_ADR leaves rd* outputs unchanged.
- Reset asserted mid-command aborts immediately and all strobes go low asynchronously. No partial done is issued.

Optional Feature:
CRA_DIAG_PARITY_EN:
- When defined, at FIN of any read, parityErr is set to paritySample XOR ^{CALL,DISP[0:4]}.
- parityErr holds until the next read completes or until reset.
- When undefined, parityErr is tied to 0 and paritySample is not stored.

Decomposition:
- Shared package cra_diag_pkg holds:
  - command encodings CMD_NOP/LOAD/READ/LOADREAD.
  - select constants SEL_STACK=0 … SEL_LOC_HI=7.
  - the state enum.
  - the EBUS field offsets (29..35).
- One natural sub-module, cra_diag_cnt: a parameterised down-counter used for both strobe and settle timing (load value, dec, zero flag).

Test Plan:
- STROBE_CYC=1, LOAD_ADR adr=11'o1234 -> 052 high 1 cycle with ebusOut[1:5]=5'b01010, then 051 high 1 cycle with ebusOut[0:5]=6'o34. done pulses 3 cycles after acceptance; never both strobes high.
- READ_ALL with an EBUS model returning adr=11'o0777, loc=11'o0776, sbrRet=11'o1777, stack=5'h16 -> diag steps 0..7, each held 3 cycles. rdAdr=0777, rdLoc=0776, rdSbrRet=1777, rdStackAdr=16. done at cycle 25.
- LOAD_THEN_READ adr=11'o0000 -> strobes followed immediately by select 0; a single done at cycle 2+24+1.
- reqValid held high throughout a command -> exactly one accept; reqReady returns to 1 one cycle after done.
- resetN pulsed low during RD_WAIT of sel3 -> outputs cleared asynchronously, no done; a new READ_ALL after release completes normally.
- With CRA_DIAG_PARITY_EN, model dispParity wrong (CALL=1, DISP=0, sample=0) -> parityErr=1 at FIN. Corrected model -> parityErr=0.

Source files
------------

// File: rtl/cra_diag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cra_diag_pkg
// Purpose  : Shared definitions for the CRA diagnostic initiator. It holds the
//            command encodings, the diag[4:6] read-select codes, the
//            controller state enum and the EBUS field offsets.
// Notes    : EBUS and CRAM addresses use KL numbering, where bit 0 is the MSB.
//            ebus_vec() maps a KL EBUS bit number onto the [35:0] vector index.
// Revision : 1.0  initial release
// ============================================================================
package cra_diag_pkg;

  // Command encodings on reqCmd
  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_LOAD     = 2'b01;
  localparam logic [1:0] CMD_READ     = 2'b10;
  localparam logic [1:0] CMD_LOADREAD = 2'b11;

  // diag[4:6] read-select codes
  localparam logic [2:0] SEL_STACK  = 3'd0;
  localparam logic [2:0] SEL_DISP   = 3'd1;
  localparam logic [2:0] SEL_SBR_LO = 3'd2;
  localparam logic [2:0] SEL_SBR_HI = 3'd3;
  localparam logic [2:0] SEL_ADR_LO = 3'd4;
  localparam logic [2:0] SEL_ADR_HI = 3'd5;
  localparam logic [2:0] SEL_LOC_LO = 3'd6;
  localparam logic [2:0] SEL_LOC_HI = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_HI   = 3'd1,
    ST_WR_LO   = 3'd2,
    ST_RD_SET  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_CAP  = 3'd5,
    ST_FIN     = 3'd6
  } state_e;

  // EBUS geometry and the KL bit numbers of the CRA read-back fields
  localparam int EBUS_W        = 36;
  localparam int EBUS_KL_SPARE = 29;
  localparam int EBUS_KL_FLAG  = 30;
  localparam int EBUS_KL_F5    = 31;
  localparam int EBUS_KL_LAST  = 35;

  // Converts a KL EBUS bit number (0 = MSB) into a [35:0] vector index.
  function automatic int ebus_vec(input int kl);
    return EBUS_W - 1 - kl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cra_diag_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cra_diag_cnt
// Purpose  : Loadable down-counter. It times both the write strobes and the
//            read settle interval. It stops at zero.
// Ports    : clk, resetN     clock and asynchronous active-low reset
//            i_load          load i_loadVal; has priority over i_dec
//            i_loadVal       value to load
//            i_dec           decrement by one; held at zero once reached
//            o_zero          count is zero
// Revision : 1.0  initial release
// ============================================================================
module cra_diag_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_loadVal;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cra_diag_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cra_diag_ctl
// Purpose  : Diagnostic-side initiator for the CRA diagnostic port.
//            - LOAD_ADR writes the 11-bit CRAM address. It writes the high
//              5 bits with function 052 and then the low 6 bits with 051.
//            - READ_ALL steps diag[4:6] through 0..7 with 14X asserted. It
//              assembles the captured EBUS fields into the rd* outputs.
// Ports    : clk, resetN                      clock, async active-low reset
//            reqValid/reqReady/reqCmd/reqAdr  command request handshake
//            done                             one-cycle completion pulse
//            diaFunc051/052, diagReadFunc14X  diag function strobes
//            diag                             read select (diag[4:6])
//            ebusOut / ebusIn                 EBUS write / read data
//            rdAdr, rdLoc, rdSbrRet,
//            rdStackAdr, rdDisp               captured CRA state
//            parityErr                        dispatch parity error
// Options  : `define CRA_DIAG_PARITY_EN enables the dispatch parity check.
//            When it is not defined, parityErr is tied low.
// Revision : 1.0  initial release
// ============================================================================
module cra_diag_ctl
  import cra_diag_pkg::*;
#(
  parameter int STROBE_CYC = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqCmd,
  input  logic [10:0] reqAdr,
  output logic        done,
  output logic        diaFunc051,
  output logic        diaFunc052,
  output logic        diagReadFunc14X,
  output logic [2:0]  diag,
  output logic [35:0] ebusOut,
  input  logic [35:0] ebusIn,
  output logic [10:0] rdAdr,
  output logic [10:0] rdLoc,
  output logic [10:0] rdSbrRet,
  output logic [4:0]  rdStackAdr,
  output logic [7:0]  rdDisp,
  output logic        parityErr
);

  // The counter holds (cycles - 1). RD_SET already uses one settle cycle,
  // so RD_WAIT is loaded with SETTLE_CYC-2. RD_WAIT is skipped when
  // SETTLE_CYC is 1.
  localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] c_SETTLE_LD = 4'((SETTLE_CYC > 1) ? (SETTLE_CYC - 2) : 0);

  // Vector indices of the EBUS bits used here.
  // WR_HI drives KL[1:5]. WR_LO drives KL[0:5].
  localparam int c_OUT_HI_MSB = ebus_vec(1);
  localparam int c_OUT_LO_MSB = ebus_vec(0);
  localparam int c_IN_FLAG    = ebus_vec(EBUS_KL_FLAG);
  localparam int c_IN_F5      = ebus_vec(EBUS_KL_F5);

  state_e      r_state;
  state_e      w_next;
  logic        r_live;
  logic [1:0]  r_cmd;
  logic [10:0] r_adr;
  logic [2:0]  r_sel;

  logic        w_accept;
  logic        w_cntLoad;
  logic [3:0]  w_cntLoadVal;
  logic        w_cntDec;
  logic        w_cntZero;
  logic        w_selClr;
  logic        w_selInc;

  logic        w_flag;
  logic [5:0]  w_six;
  logic [4:0]  w_five;
  logic        w_unused;

  logic [10:0] r_rdAdr;
  logic [10:0] r_rdLoc;
  logic [10:0] r_rdSbr;
  logic [4:0]  r_rdStack;
  logic [7:0]  r_rdDisp;

  // CRA fields are right-aligned on the EBUS. w_flag is KL30.
  // w_six is KL[30:35]. w_five is KL[31:35].
  assign w_flag   = ebusIn[c_IN_FLAG];
  assign w_six    = ebusIn[c_IN_FLAG -: 6];
  assign w_five   = ebusIn[c_IN_F5 -: 5];
  assign w_unused = ^ebusIn[EBUS_W-1:c_IN_FLAG+1];

  cra_diag_cnt #(
    .WIDTH (4)
  ) u_cnt (
    .clk       (clk),
    .resetN    (resetN),
    .i_load    (w_cntLoad),
    .i_loadVal (w_cntLoadVal),
    .i_dec     (w_cntDec),
    .o_zero    (w_cntZero)
  );

  // State register. r_live keeps reqReady low while reset is asserted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_cntLoad       = 1'b0;
    w_cntLoadVal    = c_STROBE_LD;
    w_cntDec        = 1'b0;
    w_selClr        = 1'b0;
    w_selInc        = 1'b0;
    reqReady        = 1'b0;
    done            = 1'b0;
    diaFunc051      = 1'b0;
    diaFunc052      = 1'b0;
    diagReadFunc14X = 1'b0;
    diag            = 3'd0;
    ebusOut         = '0;
    case (r_state)
      ST_IDLE: begin
        reqReady = r_live;
        if (reqValid && r_live) begin
          w_accept = 1'b1;
          case (reqCmd)
            CMD_LOAD, CMD_LOADREAD: begin
              w_next    = ST_WR_HI;
              w_cntLoad = 1'b1;
            end
            CMD_READ: begin
              w_next   = ST_RD_SET;
              w_selClr = 1'b1;
            end
            default: w_next = ST_FIN;
          endcase
        end
      end
      ST_WR_HI: begin
        diaFunc052                  = 1'b1;
        ebusOut[c_OUT_HI_MSB -: 5]  = r_adr[10:6];
        w_cntDec                    = 1'b1;
        if (w_cntZero) begin
          w_next    = ST_WR_LO;
          w_cntLoad = 1'b1;
        end
      end
      ST_WR_LO: begin
        diaFunc051                  = 1'b1;
        ebusOut[c_OUT_LO_MSB -: 6]  = r_adr[5:0];
        w_cntDec                    = 1'b1;
        if (w_cntZero) begin
          if (r_cmd == CMD_LOADREAD) begin
            w_next   = ST_RD_SET;
            w_selClr = 1'b1;
          end else begin
            w_next = ST_FIN;
          end
        end
      end
      ST_RD_SET: begin
        diagReadFunc14X = 1'b1;
        diag            = r_sel;
        if (SETTLE_CYC > 1) begin
          w_next       = ST_RD_WAIT;
          w_cntLoad    = 1'b1;
          w_cntLoadVal = c_SETTLE_LD;
        end else begin
          w_next = ST_RD_CAP;
        end
      end
      ST_RD_WAIT: begin
        diagReadFunc14X = 1'b1;
        diag            = r_sel;
        w_cntDec        = 1'b1;
        if (w_cntZero) begin
          w_next = ST_RD_CAP;
        end
      end
      ST_RD_CAP: begin
        diagReadFunc14X = 1'b1;
        diag            = r_sel;
        if (r_sel == SEL_LOC_HI) begin
          w_next = ST_FIN;
        end else begin
          w_selInc = 1'b1;
          w_next   = ST_RD_SET;
        end
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command latch and read-select stepping
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cmd <= CMD_NOP;
      r_adr <= '0;
      r_sel <= SEL_STACK;
    end else begin
      if (w_accept) begin
        r_cmd <= reqCmd;
        r_adr <= reqAdr;
      end
      if (w_selClr) begin
        r_sel <= SEL_STACK;
      end else if (w_selInc) begin
        r_sel <= r_sel + 3'd1;
      end
    end
  end

  // Field capture. Each select updates only its own slice.
  // rdDisp layout: [7] dispEn00_03, [6] dispEn30_37, [5] CALL, [4:0] DISP[0:4].
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rdAdr   <= '0;
      r_rdLoc   <= '0;
      r_rdSbr   <= '0;
      r_rdStack <= '0;
      r_rdDisp  <= '0;
    end else if (r_state == ST_RD_CAP) begin
      case (r_sel)
        SEL_STACK: begin
          r_rdStack   <= w_five;
          r_rdDisp[7] <= w_flag;
        end
        SEL_DISP:   r_rdDisp[5:0] <= w_six;
        SEL_SBR_LO: r_rdSbr[5:0]  <= w_six;
        SEL_SBR_HI: begin
          r_rdDisp[6]   <= w_flag;
          r_rdSbr[10:6] <= w_five;
        end
        SEL_ADR_LO: r_rdAdr[5:0]  <= w_six;
        SEL_ADR_HI: r_rdAdr[10:6] <= w_five;
        SEL_LOC_LO: r_rdLoc[5:0]  <= w_six;
        SEL_LOC_HI: r_rdLoc[10:6] <= w_five;
        default: ;
      endcase
    end
  end

`ifdef CRA_DIAG_PARITY_EN
  logic r_paritySample;
  logic r_parityErr;

  // The KL30 parity sample arrives with select 5. The error is resolved on
  // the last capture, so it is visible together with done and holds until
  // the next read.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_paritySample <= 1'b0;
      r_parityErr    <= 1'b0;
    end else if (r_state == ST_RD_CAP) begin
      if (r_sel == SEL_ADR_HI) begin
        r_paritySample <= w_flag;
      end
      if (r_sel == SEL_LOC_HI) begin
        r_parityErr <= r_paritySample ^ (^r_rdDisp[5:0]);
      end
    end
  end

  assign parityErr = r_parityErr;
`else
  assign parityErr = 1'b0;
`endif

  assign rdAdr      = r_rdAdr;
  assign rdLoc      = r_rdLoc;
  assign rdSbrRet   = r_rdSbr;
  assign rdStackAdr = r_rdStack;
  assign rdDisp     = r_rdDisp;

endmodule
`default_nettype wire

// File: tb/tb_cra_diag_ctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cra_diag_ctl
// Purpose  : Self-checking bench for cra_diag_ctl. A behavioural CRA model
//            answers on the EBUS for each diag select. Expected values come
//            from the model fields and the latency formulas.
// Revision : 1.0  initial release
// ============================================================================
module tb_cra_diag_ctl;

  localparam int P_STROBE = 1;
  localparam int P_SETTLE = 2;
  localparam int RD_CYC   = 8 * (P_SETTLE + 1);

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqCmd;
  logic [10:0] reqAdr;
  logic        done;
  logic        diaFunc051;
  logic        diaFunc052;
  logic        diagReadFunc14X;
  logic [2:0]  diag;
  logic [35:0] ebusOut;
  logic [35:0] ebusIn;
  logic [10:0] rdAdr;
  logic [10:0] rdLoc;
  logic [10:0] rdSbrRet;
  logic [4:0]  rdStackAdr;
  logic [7:0]  rdDisp;
  logic        parityErr;

  always #5 clk = ~clk;

  cra_diag_ctl #(
    .STROBE_CYC (P_STROBE),
    .SETTLE_CYC (P_SETTLE)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .reqValid        (reqValid),
    .reqReady        (reqReady),
    .reqCmd          (reqCmd),
    .reqAdr          (reqAdr),
    .done            (done),
    .diaFunc051      (diaFunc051),
    .diaFunc052      (diaFunc052),
    .diagReadFunc14X (diagReadFunc14X),
    .diag            (diag),
    .ebusOut         (ebusOut),
    .ebusIn          (ebusIn),
    .rdAdr           (rdAdr),
    .rdLoc           (rdLoc),
    .rdSbrRet        (rdSbrRet),
    .rdStackAdr      (rdStackAdr),
    .rdDisp          (rdDisp),
    .parityErr       (parityErr)
  );

  int total = 0;
  int bad   = 0;

  // CRA state presented by the EBUS model
  logic [10:0] m_adr, m_loc, m_sbr;
  logic [4:0]  m_stack;
  logic [5:0]  m_cd;        // {CALL, DISP[0:4]}
  logic        m_en03, m_en37, m_ps;

  // Expected visible read-back state
  logic [10:0] e_adr, e_loc, e_sbr;
  logic [4:0]  e_stack;
  logic [7:0]  e_disp;
  logic        e_perr;

  // The CRA answers in KL[29:35]. KL29 and all higher bits carry junk that
  // the initiator must ignore.
  logic [6:0] f7;
  always_comb begin
    f7 = 7'h7F;
    case (diag)
      3'd0: f7 = {1'b1, m_en03, m_stack};
      3'd1: f7 = {1'b1, m_cd};
      3'd2: f7 = {1'b1, m_sbr[5:0]};
      3'd3: f7 = {1'b1, m_en37, m_sbr[10:6]};
      3'd4: f7 = {1'b1, m_adr[5:0]};
      3'd5: f7 = {1'b1, m_ps, m_adr[10:6]};
      3'd6: f7 = {1'b1, m_loc[5:0]};
      default: f7 = {1'b1, 1'b1, m_loc[10:6]};
    endcase
    ebusIn = diagReadFunc14X ? {29'h15A5A5A5, f7} : 36'h5A5A5A5A5;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Places a value whose MSB sits at KL bit firstKl on the 36-bit EBUS.
  function automatic logic [35:0] kl_place(input logic [35:0] v, input int firstKl, input int width);
    return v << (36 - firstKl - width);
  endfunction

  function automatic int exp_lat(input logic [1:0] cmd);
    case (cmd)
      2'b00:   return 1;
      2'b01:   return 2 * P_STROBE + 1;
      2'b10:   return RD_CYC + 1;
      default: return 2 * P_STROBE + RD_CYC + 1;
    endcase
  endfunction

  task automatic run_cmd(input string nm, input logic [1:0] cmd, input logic [10:0] adr, input int expLat);
    int k, lat, n052, n051, nBoth, nBus, nAcc, n14, nOrd, nSelBad, first14, last051, last052, first051;
    int cnt14[8];
    int prevSel;
    bit isLoad, isRead;
    isLoad = (cmd == 2'b01) || (cmd == 2'b11);
    isRead = (cmd == 2'b10) || (cmd == 2'b11);
    lat = -1; n052 = 0; n051 = 0; nBoth = 0; nBus = 0; n14 = 0; nOrd = 0; nSelBad = 0;
    first14 = -1; last051 = -1; last052 = -1; first051 = -1; prevSel = 0;
    foreach (cnt14[s]) cnt14[s] = 0;
    k = 0;
    while (!reqReady && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " ready"}, reqReady, 1);
    reqCmd = cmd; reqAdr = adr; reqValid = 1'b1;
    nAcc = reqReady ? 1 : 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (reqValid && reqReady) nAcc++;
      if (diaFunc052 && diaFunc051) nBoth++;
      if (diaFunc052) begin
        n052++; last052 = c;
        if (ebusOut !== kl_place(36'(adr[10:6]), 1, 5)) nBus++;
      end else if (diaFunc051) begin
        n051++; last051 = c;
        if (first051 < 0) first051 = c;
        if (ebusOut !== kl_place(36'(adr[5:0]), 0, 6)) nBus++;
      end else if (ebusOut !== 36'd0) begin
        nBus++;
      end
      if (diagReadFunc14X) begin
        n14++;
        if (first14 < 0) first14 = c;
        if (int'(diag) < prevSel) nOrd++;
        prevSel = int'(diag);
        cnt14[diag]++;
      end
      if (done) begin
        lat = c;
        reqValid = 1'b0;
        break;
      end
    end
    reqValid = 1'b0;
    if (isRead) begin
      e_adr = m_adr; e_loc = m_loc; e_sbr = m_sbr; e_stack = m_stack;
      e_disp = {m_en03, m_en37, m_cd};
`ifdef CRA_DIAG_PARITY_EN
      e_perr = m_ps ^ (^m_cd);
`else
      e_perr = 1'b0;
`endif
    end
    chk({nm, " latency"}, lat, expLat);
    chk({nm, " accepts"}, nAcc, 1);
    chk({nm, " strobe overlap"}, nBoth, 0);
    chk({nm, " ebusOut errs"}, nBus, 0);
    chk({nm, " 052 cycles"}, n052, isLoad ? P_STROBE : 0);
    chk({nm, " 051 cycles"}, n051, isLoad ? P_STROBE : 0);
    if (isLoad) chk({nm, " 051 follows 052"}, first051, last052 + 1);
    chk({nm, " 14X cycles"}, n14, isRead ? RD_CYC : 0);
    chk({nm, " sel order"}, nOrd, 0);
    for (int s = 0; s < 8; s++) if (cnt14[s] != (isRead ? P_SETTLE + 1 : 0)) nSelBad++;
    chk({nm, " sel hold"}, nSelBad, 0);
    if (cmd == 2'b11) chk({nm, " read follows 051"}, first14, last051 + 1);
    chk({nm, " rdAdr"}, rdAdr, e_adr);
    chk({nm, " rdLoc"}, rdLoc, e_loc);
    chk({nm, " rdSbrRet"}, rdSbrRet, e_sbr);
    chk({nm, " rdStackAdr"}, rdStackAdr, e_stack);
    chk({nm, " rdDisp"}, rdDisp, e_disp);
    chk({nm, " parityErr"}, parityErr, e_perr);
    @(negedge clk);
    chk({nm, " done single"}, done, 0);
    chk({nm, " ready after"}, reqReady, 1);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [10:0] adr;
    logic [10:0] madr, mloc, msbr;
    logic [4:0]  mstack;
    logic [5:0]  mcd;
    logic        men03, men37, mps;
    int          lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd;
    resetN = 1'b0; reqValid = 1'b0; reqCmd = 2'b00; reqAdr = '0;
    m_adr = '0; m_loc = '0; m_sbr = '0; m_stack = '0; m_cd = '0;
    m_en03 = 1'b0; m_en37 = 1'b0; m_ps = 1'b0;
    e_adr = '0; e_loc = '0; e_sbr = '0; e_stack = '0; e_disp = '0; e_perr = 1'b0;

    vt[0] = '{2'b01, 11'o1234, 11'o0000, 11'o0000, 11'o0000, 5'h00, 6'o00, 1'b0, 1'b0, 1'b0, 3};
    vt[1] = '{2'b10, 11'o0000, 11'o0777, 11'o0776, 11'o1777, 5'h16, 6'o52, 1'b1, 1'b0, 1'b1, 25};
    vt[2] = '{2'b11, 11'o0000, 11'o2345, 11'o1020, 11'o0001, 5'h09, 6'o41, 1'b0, 1'b1, 1'b0, 27};
    vt[3] = '{2'b00, 11'o3777, 11'o0000, 11'o0000, 11'o0000, 5'h00, 6'o00, 1'b0, 1'b0, 1'b0, 1};
    vt[4] = '{2'b01, 11'o3777, 11'o0000, 11'o0000, 11'o0000, 5'h00, 6'o00, 1'b0, 1'b0, 1'b0, 3};
    vt[5] = '{2'b10, 11'o0000, 11'o3777, 11'o3777, 11'o3777, 5'h1F, 6'o77, 1'b1, 1'b1, 1'b1, 25};
    vt[6] = '{2'b10, 11'o0000, 11'o0123, 11'o0456, 11'o0765, 5'h03, 6'o40, 1'b0, 1'b0, 1'b0, 25};
    vt[7] = '{2'b10, 11'o0000, 11'o0123, 11'o0456, 11'o0765, 5'h03, 6'o40, 1'b0, 1'b0, 1'b1, 25};

    #1;
    chk("reset reqReady", reqReady, 0);
    chk("reset done", done, 0);
    chk("reset strobes", {diaFunc051, diaFunc052, diagReadFunc14X}, 0);
    chk("reset diag", diag, 0);
    chk("reset ebusOut", ebusOut, 0);
    chk("reset rd fields", {rdAdr, rdLoc, rdSbrRet, rdStackAdr, rdDisp, parityErr}, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("ready after reset", reqReady, 1);

    for (int i = 0; i < 8; i++) begin
      m_adr = vt[i].madr; m_loc = vt[i].mloc; m_sbr = vt[i].msbr; m_stack = vt[i].mstack;
      m_cd = vt[i].mcd; m_en03 = vt[i].men03; m_en37 = vt[i].men37; m_ps = vt[i].mps;
      run_cmd($sformatf("vec%0d", i), vt[i].cmd, vt[i].adr, vt[i].lat);
    end

    // Reset asserted during RD_WAIT of select 3
    m_adr = 11'o1357; m_loc = 11'o0246; m_sbr = 11'o3001; m_stack = 5'h0B;
    m_cd = 6'o25; m_en03 = 1'b1; m_en37 = 1'b1; m_ps = 1'b0;
    reqCmd = 2'b10; reqAdr = '0; reqValid = 1'b1;
    k = 0;
    while (!(diagReadFunc14X && diag == 3'd3) && k < 100) begin
      @(negedge clk);
      k++;
      if (reqReady == 1'b0) reqValid = 1'b0;
    end
    @(negedge clk);
    chk("abort sel3 wait", {diagReadFunc14X, diag}, {1'b1, 3'd3});
    resetN = 1'b0;
    reqValid = 1'b0;
    #1;
    chk("abort 14X", diagReadFunc14X, 0);
    chk("abort diag", diag, 0);
    chk("abort ready", reqReady, 0);
    chk("abort rd fields", {rdAdr, rdLoc, rdSbrRet, rdStackAdr, rdDisp, parityErr}, 0);
    e_adr = '0; e_loc = '0; e_sbr = '0; e_stack = '0; e_disp = '0; e_perr = 1'b0;
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    resetN = 1'b1;
    @(negedge clk);
    if (done) nd++;
    chk("abort no done", nd, 0);
    run_cmd("after abort", 2'b10, 11'o0000, exp_lat(2'b10));

    // Randomised commands against the CRA model
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  rc;
      logic [10:0] ra;
      rc = 2'($urandom_range(0, 3));
      ra = 11'($urandom);
      m_adr = 11'($urandom); m_loc = 11'($urandom); m_sbr = 11'($urandom);
      m_stack = 5'($urandom); m_cd = 6'($urandom);
      m_en03 = 1'($urandom); m_en37 = 1'($urandom); m_ps = 1'($urandom);
      run_cmd($sformatf("rnd%0d", i), rc, ra, exp_lat(rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
